sm_accumulator: RTL
===================

SM_ACCUMULATOR -- requirements
Module: sm_accumulator

Interface
REQ-001 Parameter N, default `N from config.svh: total word width (1 sign bit + N-1 magnitude bits).
REQ-002 Parameter F, default `F from config.svh: fraction bits inside the magnitude field; does not affect arithmetic.
REQ-003 Parameter MAX_LEN, default 64: maximum number of beats per vector; CW = $clog2(MAX_LEN+1).
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  block can accept an input beat.
REQ-008 in_data  in  N  sign-magnitude operand.
REQ-009 in_last  in  1  final beat of the current vector.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 out_data  out  N  sign-magnitude sum of the vector.
REQ-013 out_cnt  out  CW  number of beats summed.
REQ-014 out_ovf  out  1  magnitude overflow occurred at least once in this vector.
REQ-015 out_trunc  out  1  vector was closed at MAX_LEN without in_last.

Function
REQ-016 States SHALL be IDLE, ACC and HOLD; a beat is accepted when in_valid && in_ready.
REQ-017 in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD.
REQ-018 IDLE: an accepted beat loads acc = norm(in_data) and cnt = 1, then goes to ACC, or to HOLD if in_last is set.
REQ-019 ACC: an accepted beat sets acc = acc + norm(in_data) and cnt = cnt+1; state stays ACC, or goes to HOLD if in_last is set or cnt+1 == MAX_LEN.
REQ-020 A beat accepted at cycle t with in_last set SHALL produce out_valid = 1 at cycle t+1, with out_data, out_cnt, out_ovf and out_trunc stable until the output handshake.
REQ-021 HOLD: out_valid = 1; out_valid && out_ready SHALL return the state to IDLE at the next edge, with out_valid = 0 in that cycle.
REQ-022 Cycles with in_valid = 0 in ACC SHALL leave acc and cnt unchanged (gaps allowed).
REQ-023 Addition SHALL be sign-magnitude:
  - equal signs: add the magnitudes, keep the sign;
  - different signs: subtract the smaller magnitude from the larger, taking the sign of the larger.
REQ-024 norm(): a magnitude of 0 SHALL always carry sign 0; -0 in SHALL be treated as +0; -0 SHALL never be output.
REQ-025 A carry out of bit N-2 SHALL set the sticky ovf flag for the vector; ovf clears on the next IDLE load.
REQ-026 If the beat accepted at cnt+1 == MAX_LEN has in_last = 0, out_trunc SHALL be 1; if in_last = 1 at that beat, out_trunc SHALL be 0.
REQ-027 Beats arriving after a truncated close SHALL start a new vector.
REQ-028 Simultaneous in_valid in HOLD SHALL NOT be accepted; no beat is lost (in_ready = 0).

Reset
REQ-029 With rst_n = 0 at a clock edge, state SHALL go to IDLE and acc, cnt, ovf, trunc SHALL go to 0.
REQ-030 During reset, out_valid = 0, out_data = 0, out_cnt = 0, out_ovf = 0, out_trunc = 0 and in_ready = 0.
REQ-031 in_ready SHALL go to 1 in the first cycle after rst_n returns to 1.
REQ-032 Reset mid-vector or in HOLD SHALL discard the partial or pending result with no output handshake.

Configuration
REQ-033 Macro SM_ACC_SAT_EN defined: on overflow, the magnitude SHALL clamp to all-ones (2^(N-1)-1) with the sign kept, and later beats SHALL continue from the clamped value.
REQ-034 Macro SM_ACC_SAT_EN undefined: on overflow, the magnitude SHALL wrap modulo 2^(N-1); out_ovf SHALL still be reported in both builds.

Structure
REQ-035 Package sm_pkg SHALL hold:
  - the state enum typedef (IDLE/ACC/HOLD);
  - the sm_word_t typedef;
  - functions sm_norm and sm_mag_max.
REQ-036 The combinational adder SHALL be sub-module sm_add_core (inputs a and b; outputs sum and ovf; saturate/wrap per the macro).
REQ-037 sm_accumulator SHALL contain only the FSM, registers, counter and handshake.

Verification (N=16, F=8)
REQ-038 Beats 0x0180, 0x8080 (last) -> out_data 0x0100, out_cnt 2, out_ovf 0, out_valid at cycle t+1.
REQ-039 Beats 0x0100, 0x8100 (last), and a single beat 0x8000 (last) -> both give out_data 0x0000.
REQ-040 Beats 0x7F00, 0x0200 (last) -> with SAT_EN 0x7FFF / ovf 1; without SAT_EN 0x0100 / ovf 1.
REQ-041 MAX_LEN=4, five beats of 0x0001 with no in_last -> first result 0x0004, cnt 4, trunc 1; the fifth beat starts a new vector.
REQ-042 out_ready held low 3 cycles in HOLD -> outputs stable and in_ready 0 throughout; the handshake returns to IDLE.
REQ-043 rst_n low during ACC after 2 beats -> no output; the next vector sums from 0.

Source files
------------

// File: rtl/sm_pkg.sv
// sm_pkg: shared state enum, word type and sign-magnitude helpers.
// Width defaults come from `N / `F, set here to 16 / 8 if not predefined.
`ifndef N
`define N 16
`endif
`ifndef F
`define F 8
`endif

package sm_pkg;

  localparam int SM_W    = `N;
  localparam int SM_WMAX = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } sm_state_e;

  typedef logic [SM_W-1:0] sm_word_t;

  // All-ones magnitude for an n-bit word (n-1 magnitude bits).
  function automatic logic [SM_WMAX-1:0] sm_mag_max(input int n);
    return (SM_WMAX'(1) << (n - 1)) - SM_WMAX'(1);
  endfunction

  // Zero magnitude always carries a positive sign.
  function automatic logic [SM_WMAX-1:0] sm_norm(
    input logic [SM_WMAX-1:0] w,
    input int                 n
  );
    logic [SM_WMAX-1:0] mag;
    logic [SM_WMAX-1:0] sgn;
    mag = w & sm_mag_max(n);
    sgn = w & (SM_WMAX'(1) << (n - 1));
    return (mag == '0) ? '0 : (mag | sgn);
  endfunction

endpackage

// File: rtl/sm_add_core.sv
// sm_add_core: combinational sign-magnitude adder with overflow flag.
// SM_ACC_SAT_EN defined: clamp magnitude on overflow; else wrap.
module sm_add_core
  import sm_pkg::*;
#(
  parameter int N = `N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         ovf
);

  localparam int M = N - 1;

  logic [M:0]   mag_s;
  logic [M-1:0] mag_r;
  logic         sign_r;

  // Same signs add magnitudes; mixed signs subtract toward the larger.
  always_comb begin
    mag_s  = '0;
    mag_r  = '0;
    sign_r = a[N-1];
    ovf    = 1'b0;
    if (a[N-1] == b[N-1]) begin
      mag_s = {1'b0, a[M-1:0]} + {1'b0, b[M-1:0]};
      ovf   = mag_s[M];
`ifdef SM_ACC_SAT_EN
      mag_r = ovf ? M'(sm_mag_max(N)) : mag_s[M-1:0];
`else
      mag_r = mag_s[M-1:0];
`endif
    end else if (a[M-1:0] >= b[M-1:0]) begin
      mag_r  = a[M-1:0] - b[M-1:0];
      sign_r = a[N-1];
    end else begin
      mag_r  = b[M-1:0] - a[M-1:0];
      sign_r = b[N-1];
    end
    sum = N'(sm_norm(SM_WMAX'({sign_r, mag_r}), N));
  end

endmodule

// File: rtl/sm_accumulator.sv
// sm_accumulator: streaming sign-magnitude vector summer, IDLE/ACC/HOLD.
// Overflow behaviour of the adder selected by macro SM_ACC_SAT_EN.
module sm_accumulator
  import sm_pkg::*;
#(
  parameter  int N       = `N,
  parameter  int F       = `F,
  parameter  int MAX_LEN = 64,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] out_cnt,
  output logic          out_ovf,
  output logic          out_trunc
);

  if (F >= N) begin : g_bad_f
    $error("fraction field wider than magnitude");
  end

  sm_state_e     state_q;
  logic [N-1:0]  acc_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          trunc_q;

  logic [N-1:0]  beat_n;
  logic [N-1:0]  acc_d;
  logic [CW-1:0] cnt_d;
  logic          add_ovf;
  logic          at_max;
  logic          take;

  assign beat_n = N'(sm_norm(SM_WMAX'(in_data), N));

  sm_add_core #(
    .N(N)
  ) u_add (
    .a  (acc_q),
    .b  (beat_n),
    .sum(acc_d),
    .ovf(add_ovf)
  );

  assign cnt_d    = cnt_q + CW'(1);
  assign at_max   = (cnt_d == CW'(MAX_LEN));
  assign in_ready = rst_n && (state_q != HOLD);
  assign take     = in_valid && in_ready;

  assign out_valid = rst_n && (state_q == HOLD);
  assign out_data  = rst_n ? acc_q : '0;
  assign out_cnt   = rst_n ? cnt_q : '0;
  assign out_ovf   = rst_n && ovf_q;
  assign out_trunc = rst_n && trunc_q;

  // Vector FSM: load, accumulate, hold result until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take) begin
            acc_q   <= beat_n;
            cnt_q   <= CW'(1);
            ovf_q   <= 1'b0;
            trunc_q <= !in_last && (MAX_LEN == 1);
            state_q <= (in_last || MAX_LEN == 1) ? HOLD : ACC;
          end
        end
        ACC: begin
          if (take) begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_q | add_ovf;
            trunc_q <= at_max && !in_last;
            if (in_last || at_max) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
